// File: rtl/scope_capture_ctrl.sv
// Ping-pong capture sequencer for the scope's two sample buffers: triggered records go to
// the back buffer while the display reads the front one; buffers swap at frame end.
module scope_capture_ctrl #(
  parameter int unsigned DEPTH        = 640,
  parameter int unsigned ADDR_W       = 10,
  parameter int unsigned SAMPLE_W     = 9,
  parameter int unsigned AUTO_TIMEOUT = 4096
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [SAMPLE_W-1:0] sample,
  input  logic                valid,
  input  logic [SAMPLE_W-1:0] trig_level,
  input  logic                rising,
  input  logic                auto_mode,
  input  logic                hold,
  input  logic                frame_end,
  input  logic [ADDR_W-1:0]   disp_addr,
  output logic [15:0]         disp_data,
  output logic [ADDR_W-1:0]   buf0_addr,
  output logic [15:0]         buf0_din,
  output logic                buf0_we,
  input  logic [15:0]         buf0_dout,
  output logic [ADDR_W-1:0]   buf1_addr,
  output logic [15:0]         buf1_din,
  output logic                buf1_we,
  input  logic [15:0]         buf1_dout,
  output logic                front_sel,
  output logic                full,
  output logic                trig_auto
);

  localparam int unsigned CNT_W = (AUTO_TIMEOUT > 1) ? $clog2(AUTO_TIMEOUT) : 1;

  typedef enum logic [1:0] {S_WAIT_TRIG, S_CAPTURE, S_DONE} state_t;

  state_t              r_state, w_state_nxt;
  logic [ADDR_W-1:0]   r_wr_ptr, w_wr_ptr_nxt;
  logic [CNT_W-1:0]    r_auto_cnt, w_auto_cnt_nxt;
  logic [SAMPLE_W-1:0] r_prev;
  logic                r_prev_ok, w_prev_ok_nxt;
  logic                r_front_sel, w_front_sel_nxt;
  logic                r_full, w_full_nxt;
  logic                r_trig_auto, w_trig_auto_nxt;
  logic                r_disp_sel;
  logic                w_we, w_back_we;
  logic                w_edge, w_forced;

  assign w_edge = valid && r_prev_ok &&
                  (rising ? (r_prev < trig_level && sample >= trig_level)
                          : (r_prev > trig_level && sample <= trig_level));
  assign w_forced = valid && auto_mode && (r_auto_cnt == CNT_W'(AUTO_TIMEOUT - 1));

  always_comb begin
    w_state_nxt     = r_state;
    w_wr_ptr_nxt    = r_wr_ptr;
    w_auto_cnt_nxt  = r_auto_cnt;
    w_prev_ok_nxt   = valid ? 1'b1 : r_prev_ok;
    w_front_sel_nxt = r_front_sel;
    w_full_nxt      = r_full;
    w_trig_auto_nxt = r_trig_auto;
    w_we            = 1'b0;
    case (r_state)
      S_WAIT_TRIG: begin
        if (valid) begin
          if (w_edge || w_forced) begin
            w_we            = 1'b1;
            w_wr_ptr_nxt    = ADDR_W'(1);
            w_trig_auto_nxt = w_forced && !w_edge;
            w_auto_cnt_nxt  = '0;
            w_state_nxt     = S_CAPTURE;
          end else begin
            w_auto_cnt_nxt = r_auto_cnt + CNT_W'(1);
          end
        end
      end
      S_CAPTURE: begin
        if (valid) begin
          w_we = 1'b1;
          if (r_wr_ptr == ADDR_W'(DEPTH - 1)) begin
            w_wr_ptr_nxt = '0;
            w_full_nxt   = 1'b1;
            w_state_nxt  = S_DONE;
          end else begin
            w_wr_ptr_nxt = r_wr_ptr + ADDR_W'(1);
          end
        end
      end
      S_DONE: begin
        if (frame_end && !hold) begin
          w_front_sel_nxt = ~r_front_sel;
          w_full_nxt      = 1'b0;
          w_prev_ok_nxt   = 1'b0;
          w_state_nxt     = S_WAIT_TRIG;
        end
      end
      default: w_state_nxt = S_WAIT_TRIG;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_WAIT_TRIG;
      r_wr_ptr    <= '0;
      r_auto_cnt  <= '0;
      r_prev      <= '0;
      r_prev_ok   <= 1'b0;
      r_front_sel <= 1'b0;
      r_full      <= 1'b0;
      r_trig_auto <= 1'b0;
      r_disp_sel  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_wr_ptr    <= w_wr_ptr_nxt;
      r_auto_cnt  <= w_auto_cnt_nxt;
      r_prev      <= valid ? sample : r_prev;
      r_prev_ok   <= w_prev_ok_nxt;
      r_front_sel <= w_front_sel_nxt;
      r_full      <= w_full_nxt;
      r_trig_auto <= w_trig_auto_nxt;
      r_disp_sel  <= r_front_sel;
    end
  end

  // Writes are suppressed while reset is held so a partial record cannot leak through.
  assign w_back_we = w_we && !reset;

  assign buf0_addr = r_front_sel ? r_wr_ptr : disp_addr;
  assign buf1_addr = r_front_sel ? disp_addr : r_wr_ptr;
  assign buf0_din  = 16'(sample);
  assign buf1_din  = 16'(sample);
  assign buf0_we   = r_front_sel && w_back_we;
  assign buf1_we   = !r_front_sel && w_back_we;

  assign disp_data = r_disp_sel ? buf1_dout : buf0_dout;
  assign front_sel = r_front_sel;
  assign full      = r_full;
  assign trig_auto = r_trig_auto;

endmodule
